// File: rtl/gene_pkg.sv
// gene_pkg: shared widths, result classes and FSM states for the gene_net sweep controller.
package gene_pkg;
    localparam int STATE_W = 8;
    localparam int RES_W   = 6;
    typedef enum logic [1:0] {FIXED = 2'd0, CYCLE = 2'd1, UNRESOLVED = 2'd2} res_class_e;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_CHECK, S_REPORT, S_DONE} state_e;
endpackage

// File: rtl/gene_hist_buf.sv
// gene_hist_buf: trajectory history with a parallel lowest-index match against entries 0..n.
module gene_hist_buf
    import gene_pkg::*;
#(
    parameter int MAX_STEPS = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               we,
    input  logic [RES_W-1:0]   wr_idx,
    input  logic [STATE_W-1:0] wr_data,
    input  logic [STATE_W-1:0] cmp_val,
    input  logic [RES_W-1:0]   n,
    output logic               hit,
    output logic [RES_W-1:0]   hit_idx
);
    logic [STATE_W-1:0] mem [MAX_STEPS];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MAX_STEPS; i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < MAX_STEPS; i++)
                if (clr) mem[i] <= '0;
                else if (we && wr_idx == RES_W'(i)) mem[i] <= wr_data;
        end
    end
    // descending scan so the lowest matching index is the one that sticks
    always_comb begin
        hit = 1'b0;
        hit_idx = '0;
        for (int i = MAX_STEPS - 1; i >= 0; i--)
            if (RES_W'(i) <= n && mem[i] == cmp_val) begin
                hit = 1'b1;
                hit_idx = RES_W'(i);
            end
    end
endmodule

// File: rtl/gene_sweep_ctrl.sv
// gene_sweep_ctrl: sweeps initial states through gene_net and classifies each trajectory.
// Define GENE_SWEEP_STATS_EN to add per-class counters of accepted records.
module gene_sweep_ctrl
    import gene_pkg::*;
#(
    parameter int MAX_STEPS = 16,
    parameter int NET_LAT   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [STATE_W-1:0] start_val,
    input  logic [STATE_W-1:0] end_val,
    output logic [STATE_W-1:0] net_x_in,
    input  logic [STATE_W-1:0] net_x_out,
    output logic               busy,
    output logic               done,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [STATE_W-1:0] res_init,
    output logic [1:0]         res_class,
    output logic [RES_W-1:0]   res_period,
    output logic [RES_W-1:0]   res_transient
`ifdef GENE_SWEEP_STATS_EN
    ,
    output logic [8:0]         stat_fixed,
    output logic [8:0]         stat_cycle,
    output logic [8:0]         stat_unres
`endif
);
    state_e             state, state_nx;
    res_class_e         cls;
    logic [STATE_W-1:0] cur_init, end_r, x;
    logic [RES_W-1:0]   n, wait_cnt, hit_idx;
    logic               hit, last, accept;

    assign last      = n == RES_W'(MAX_STEPS - 1);
    assign accept    = res_valid && res_ready;
    assign busy      = state != S_IDLE;
    assign done      = state == S_DONE;
    assign res_valid = state == S_REPORT;
    assign res_init  = cur_init;
    assign res_class = cls;

    gene_hist_buf #(.MAX_STEPS(MAX_STEPS)) u_hist (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == S_LOAD),
        .we      (state == S_ISSUE),
        .wr_idx  (n),
        .wr_data (x),
        .cmp_val (net_x_out),
        .n       (n),
        .hit     (hit),
        .hit_idx (hit_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   state_nx = start ? S_LOAD : S_IDLE;
            S_LOAD:   state_nx = S_ISSUE;
            S_ISSUE:  state_nx = S_WAIT;
            S_WAIT:   state_nx = wait_cnt == RES_W'(NET_LAT - 1) ? S_CHECK : S_WAIT;
            S_CHECK:  state_nx = hit || last ? S_REPORT : S_ISSUE;
            S_REPORT: state_nx = !accept ? S_REPORT : cur_init == end_r ? S_DONE : S_LOAD;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // cur_init is preloaded one below start_val so every LOAD is a plain increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_init      <= '0;
            end_r         <= '0;
            x             <= '0;
            n             <= '0;
            wait_cnt      <= '0;
            net_x_in      <= '0;
            cls           <= FIXED;
            res_period    <= '0;
            res_transient <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    cur_init <= start_val - 8'd1;
                    end_r    <= end_val;
                end
                S_LOAD: begin
                    cur_init <= cur_init + 8'd1;
                    x        <= cur_init + 8'd1;
                    n        <= '0;
                end
                S_ISSUE: begin
                    net_x_in <= x;
                    wait_cnt <= '0;
                end
                S_WAIT: wait_cnt <= wait_cnt + RES_W'(1);
                S_CHECK: if (hit) begin
                    cls           <= hit_idx == n ? FIXED : CYCLE;
                    res_period    <= n - hit_idx + RES_W'(1);
                    res_transient <= hit_idx;
                end else if (last) begin
                    cls           <= UNRESOLVED;
                    res_period    <= '0;
                    res_transient <= '0;
                end else begin
                    x <= net_x_out;
                    n <= n + RES_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef GENE_SWEEP_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_fixed <= '0;
            stat_cycle <= '0;
            stat_unres <= '0;
        end else if (state == S_IDLE && start) begin
            stat_fixed <= '0;
            stat_cycle <= '0;
            stat_unres <= '0;
        end else if (accept) begin
            stat_fixed <= stat_fixed + 9'(cls == FIXED);
            stat_cycle <= stat_cycle + 9'(cls == CYCLE);
            stat_unres <= stat_unres + 9'(cls == UNRESOLVED);
        end
    end
`endif
endmodule

// File: tb/tb_gene_sweep_ctrl.sv
// tb_gene_sweep_ctrl: scoreboard bench driving gene_sweep_ctrl with registered gene_net stubs.
module tb_gene_sweep_ctrl;
    typedef struct packed {
        logic [7:0] init;
        logic [1:0] cls;
        logic [5:0] per;
        logic [5:0] tr;
    } rec_t;

    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, res_ready = 1'b1;
    logic [7:0] start_val = '0, end_val = '0, net_x_in, net_x_out = '0, res_init;
    logic       busy, done, res_valid;
    logic [1:0] res_class;
    logic [5:0] res_period, res_transient;
`ifdef GENE_SWEEP_STATS_EN
    logic [8:0] stat_fixed, stat_cycle, stat_unres;
`endif

    int   n_cmp = 0, n_err = 0, done_cnt = 0, mode = 0;
    bit   rnd_ready = 1'b0, stall_prev = 1'b0;
    rec_t exp_q[$];

    gene_sweep_ctrl #(.MAX_STEPS(16), .NET_LAT(1)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .start_val     (start_val),
        .end_val       (end_val),
        .net_x_in      (net_x_in),
        .net_x_out     (net_x_out),
        .busy          (busy),
        .done          (done),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_init      (res_init),
        .res_class     (res_class),
        .res_period    (res_period),
        .res_transient (res_transient)
`ifdef GENE_SWEEP_STATS_EN
        ,
        .stat_fixed    (stat_fixed),
        .stat_cycle    (stat_cycle),
        .stat_unres    (stat_unres)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] f(input int md, input logic [7:0] v);
        case (md)
            0: return v;
            1: return ~v;
            2: return v + 8'd1;
            3: return v >> 1;
            default: return {6'd0, v[1:0] + 2'd1};
        endcase
    endfunction

    // one-cycle registered stub stands in for gene_net
    always @(posedge clk) net_x_out <= f(mode, net_x_in);

    function automatic rec_t model(input int md, input logic [7:0] init);
        logic [7:0] h [16];
        logic [7:0] v;
        rec_t r;
        r = '{init: init, cls: 2'd2, per: 6'd0, tr: 6'd0};
        v = init;
        for (int s = 0; s < 16; s++) begin
            h[s] = v;
            v = f(md, v);
            for (int k = 0; k <= s; k++)
                if (h[k] == v) begin
                    r.cls = k == s ? 2'd0 : 2'd1;
                    r.per = 6'(s - k + 1);
                    r.tr  = 6'(k);
                    return r;
                end
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) stall_prev = 1'b0;
        else begin
            if (done) done_cnt++;
            if (stall_prev) check("valid_held", res_valid, 1);
            if (res_valid) begin
                check("rec_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    check("res_init", res_init, exp_q[0].init);
                    check("res_class", res_class, exp_q[0].cls);
                    check("res_period", res_period, exp_q[0].per);
                    check("res_transient", res_transient, exp_q[0].tr);
                    if (res_ready) void'(exp_q.pop_front());
                end
            end
            stall_prev = res_valid && !res_ready;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        res_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic sweep(input int md, input logic [7:0] s, input logic [7:0] e,
                         input bit timed, input bit spam);
        logic [7:0] v;
        int cyc;
        bit got_done;
        mode = md;
        v = s;
        while (1) begin
            exp_q.push_back(model(md, v));
            if (v == e) break;
            v++;
        end
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1; start_val = s; end_val = e;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        if (timed) begin
            cyc = 0;
            while (!res_valid && cyc < 200) begin
                @(negedge clk);
                cyc++;
            end
            check("cycles_to_valid", cyc, 49);
        end
        cyc = 0;
        got_done = 1'b0;
        while (!got_done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            got_done = done;
            start = spam && !done && $urandom_range(0, 5) == 0;
            start_val = 8'($urandom);
            end_val = 8'($urandom);
        end
        start = 1'b0;
        check("done_seen", got_done, 1);
        repeat (3) @(negedge clk);
        check("done_pulses", done_cnt, 1);
        check("queue_drained", exp_q.size(), 0);
        check("idle_after_done", busy, 0);
    endtask

    initial begin
        #3 rst = 1'b0;
        #4;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", res_valid, 0);
        check("rst_net_x_in", net_x_in, 0);
        check("rst_res_init", res_init, 0);
        check("rst_res_class", res_class, 0);
        check("rst_res_period", res_period, 0);
        check("rst_res_transient", res_transient, 0);
        @(negedge clk);
        rst = 1'b1;
        sweep(0, 8'd0, 8'd255, 1'b0, 1'b0);
        sweep(1, 8'd56, 8'd56, 1'b0, 1'b0);
        sweep(2, 8'd3, 8'd4, 1'b1, 1'b0);
        sweep(3, 8'd56, 8'd60, 1'b0, 1'b0);
        sweep(4, 8'd56, 8'd58, 1'b0, 1'b0);
        sweep(0, 8'd0, 8'd9, 1'b0, 1'b0);
`ifdef GENE_SWEEP_STATS_EN
        check("stat_fixed", stat_fixed, 10);
        check("stat_cycle", stat_cycle, 0);
        check("stat_unres", stat_unres, 0);
`endif
        rnd_ready = 1'b1;
        sweep(0, 8'd250, 8'd5, 1'b0, 1'b1);
        rnd_ready = 1'b0;
        mode = 2;
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1; start_val = 8'd3; end_val = 8'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("busy_mid_traj", busy, 1);
        #2 rst = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_valid", res_valid, 0);
        check("abort_net_x_in", net_x_in, 0);
        check("abort_res_init", res_init, 0);
        check("abort_res_period", res_period, 0);
        check("abort_res_transient", res_transient, 0);
`ifdef GENE_SWEEP_STATS_EN
        check("abort_stat_fixed", stat_fixed, 0);
`endif
        @(negedge clk);
        rst = 1'b1;
        repeat (60) @(negedge clk);
        check("abort_no_done", done_cnt, 0);
        check("abort_idle", busy, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
